// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - VGA raster constants and shared pixel/coordinate types
package vga_pkg;
    localparam int H_ACTIVE = 640;
    localparam int H_TOTAL  = 800;
    localparam int V_ACTIVE = 480;
    localparam int V_TOTAL  = 525;

    typedef logic [7:0] pixel_t;
    typedef logic [9:0] coord_t;
endpackage

// File: rtl/vga_valid_pipe.sv
// rtl/vga_valid_pipe.sv - fixed-depth flag delay line with synchronous active-low clear
module vga_valid_pipe #(
    parameter int DEPTH = 2
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic q_o
);

    logic [DEPTH-1:0] sr_q;
    logic [DEPTH-1:0] sr_d;

    always_comb begin
        sr_d = (sr_q << 1) | DEPTH'(d_i);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/vga_pixel_fetch.sv
// rtl/vga_pixel_fetch.sv - look-ahead framebuffer fetch feeding the VGA output stage
// Optional double buffering with swap handshake when FETCH_DBUF_EN is defined.
module vga_pixel_fetch
    import vga_pkg::*;
#(
    parameter int     READ_LAT   = 1,
    parameter int     IMG_W_LOG2 = 8,
    parameter int     IMG_H_LOG2 = 8,
    parameter int     SCALE_LOG2 = 0,
    parameter int     X0         = 192,
    parameter int     Y0         = 112,
    parameter pixel_t BORDER     = 8'h00
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [9:0]                       x,
    input  logic [9:0]                       y,
`ifdef FETCH_DBUF_EN
    output logic [IMG_W_LOG2+IMG_H_LOG2:0]   mem_addr,
`else
    output logic [IMG_W_LOG2+IMG_H_LOG2-1:0] mem_addr,
`endif
    output logic                             mem_rd_en,
    input  logic [7:0]                       mem_rdata,
    output logic [7:0]                       pixel,
    input  logic                             swap_req,
    output logic                             swap_ack
);

    localparam int LA = READ_LAT + 1;
`ifdef FETCH_DBUF_EN
    localparam int AW = IMG_W_LOG2 + IMG_H_LOG2 + 1;
`else
    localparam int AW = IMG_W_LOG2 + IMG_H_LOG2;
`endif
    localparam logic [11:0] WIN_W = 12'((1 << IMG_W_LOG2) << SCALE_LOG2);
    localparam logic [11:0] WIN_H = 12'((1 << IMG_H_LOG2) << SCALE_LOG2);

    logic [11:0]           xs;
    logic [11:0]           xl;
    logic [11:0]           dx;
    logic [11:0]           dy;
    logic [11:0]           dx_s;
    logic [11:0]           dy_s;
    logic [9:0]            y_inc;
    logic [9:0]            yl;
    logic                  wrap;
    logic                  in_range;
    logic                  in_win;
    logic                  flag;
    logic [IMG_H_LOG2-1:0] row;
    logic [IMG_W_LOG2-1:0] col;
    logic [AW-1:0]         addr_d;
    logic [AW-1:0]         addr_q;
    logic                  rd_en_d;
    logic                  rd_en_q;
    logic                  unused_bits;
`ifdef FETCH_DBUF_EN
    logic                  swap_pt;
    logic                  front_d;
    logic                  front_q;
    logic                  ack_d;
    logic                  ack_q;
`endif

    // Offsets below the window wrap to large unsigned values, so one compare covers both edges.
    always_comb begin
        xs       = {2'b00, x} + 12'(LA);
        wrap     = xs >= 12'(H_TOTAL);
        xl       = wrap ? (xs - 12'(H_TOTAL)) : xs;
        y_inc    = (y == 10'(V_TOTAL - 1)) ? 10'd0 : (y + 10'd1);
        yl       = wrap ? y_inc : y;
        dx       = xl - 12'(X0);
        dy       = {2'b00, yl} - 12'(Y0);
        dx_s     = dx >> SCALE_LOG2;
        dy_s     = dy >> SCALE_LOG2;
        row      = dy_s[IMG_H_LOG2-1:0];
        col      = dx_s[IMG_W_LOG2-1:0];
        in_range = (x < 10'(H_TOTAL)) && (y < 10'(V_TOTAL));
        in_win   = in_range && (dx < WIN_W) && (dy < WIN_H);
    end

    always_comb begin
        addr_d  = addr_q;
        rd_en_d = in_win;
        if (in_win) begin
`ifdef FETCH_DBUF_EN
            addr_d = {front_q, row, col};
`else
            addr_d = {row, col};
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q  <= '0;
            rd_en_q <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            rd_en_q <= rd_en_d;
        end
    end

`ifdef FETCH_DBUF_EN
    // Swap lands on the first blanking line so the next frame's first read sees the new buffer.
    always_comb begin
        swap_pt = in_range && (xl == 12'd0) && (yl == 10'(V_ACTIVE));
        ack_d   = swap_pt && swap_req;
        front_d = front_q ^ ack_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            front_q <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            front_q <= front_d;
            ack_q   <= ack_d;
        end
    end

    assign swap_ack    = ack_q;
    assign unused_bits = ^{dx_s, dy_s};
`else
    assign swap_ack    = 1'b0;
    assign unused_bits = ^{dx_s, dy_s, swap_req};
`endif

    vga_valid_pipe #(
        .DEPTH (LA)
    ) u_flag_pipe (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .d_i     (in_win),
        .q_o     (flag)
    );

    assign mem_addr  = addr_q;
    assign mem_rd_en = rd_en_q;
    assign pixel     = flag ? mem_rdata : BORDER;

endmodule

// File: doc/vga_pixel_fetch.md
# vga_pixel_fetch

- Framebuffer read stage that sits directly upstream of the VGA output module.
- Takes the raster position (x, y) from the VGA controller and issues look-ahead reads to a synchronous framebuffer RAM.
- Returns the 8-bit `pixel` for the current position in the same cycle the controller presents it.
- Positions outside the image window are driven with a constant border colour.

## Interface

Parameters:
- `READ_LAT`, 1 — framebuffer RAM read latency in cycles (≥1).
- `IMG_W_LOG2`, 8 — image width = 2^IMG_W_LOG2 source pixels.
- `IMG_H_LOG2`, 8 — image height = 2^IMG_H_LOG2 source pixels.
- `SCALE_LOG2`, 0 — each source pixel is displayed as a 2^SCALE_LOG2 square.
- `X0`, 192 — window left edge, in screen pixels.
- `Y0`, 112 — window top edge, in screen pixels.
- `BORDER`, 8'h00 — pixel value driven outside the window.

Ports:
- `clk` in 1 — pixel clock (same as `vga_clk`). One clock only.
- `rst_n` in 1 — reset, synchronous, active-low.
- `x` in 10 — current horizontal position from the controller.
- `y` in 10 — current vertical position from the controller.
- `mem_addr` out AW — framebuffer read address. AW = IMG_W_LOG2+IMG_H_LOG2, plus 1 with `FETCH_DBUF_EN`.
- `mem_rd_en` out 1 — read strobe.
- `mem_rdata` in 8 — RAM data, valid READ_LAT cycles after the address.
- `pixel` out 8 — pixel for the current (x, y).
- `swap_req` in 1 — level request to swap buffers (`FETCH_DBUF_EN` only).
- `swap_ack` out 1 — one-cycle pulse when a swap is taken.

## Operation

- Look-ahead distance LA = READ_LAT+1: 1 cycle for the address register plus the RAM latency.
- Look-ahead position:
  - xl = x+LA.
  - If xl ≥ H_TOTAL: xl −= H_TOTAL and yl = y+1, with yl = 0 when y+1 = V_TOTAL.
  - Otherwise yl = y.
- In-window test: X0 ≤ xl < X0+(2^IMG_W_LOG2 << SCALE_LOG2), and the same form for yl against Y0 and image height.
  - An input x ≥ H_TOTAL or y ≥ V_TOTAL is out of window.
- Address: mem_addr = {front_sel, ((yl−Y0)>>SCALE_LOG2), ((xl−X0)>>SCALE_LOG2)}.
  - Fields are truncated to IMG_H_LOG2 and IMG_W_LOG2 bits; concatenation only, no multiplier.
  - `front_sel` exists only with `FETCH_DBUF_EN`.
- mem_rd_en = in-window. Out of window, mem_addr holds its previous value.
- The in-window flag is delayed LA cycles. pixel = delayed_flag ? mem_rdata : BORDER (combinational mux).
- The block holds no state beyond the pipeline, so it never needs to resynchronise to the raster.

## Timing

- Reset values, held while rst_n = 0:
  - mem_addr = 0, mem_rd_en = 0.
  - flag pipeline cleared, so pixel = BORDER.
  - front_sel = 0, swap_ack = 0.
- Cycle t: x, y sampled.
- Cycle t+1: mem_addr and mem_rd_en registered.
- Cycle t+1+READ_LAT = t+LA: mem_rdata valid and pixel driven, while the controller presents position x+LA.
- Reset released mid-frame:
  - The first LA cycles output BORDER.
  - Fetching resumes from the first post-reset sample; no frame wait.
- Line and frame wrap inside the look-ahead are handled combinationally. There is no bubble at the wrap.

## Configuration

- `FETCH_DBUF_EN` defined:
  - Two frame buffers; `front_sel` is the mem_addr MSB.
  - Swap point: the cycle where (xl, yl) = (0, V_ACTIVE).
  - If swap_req = 1 at the swap point: front_sel toggles and swap_ack pulses high for exactly one cycle (next cycle).
  - If swap_req = 0 at the swap point: nothing changes.
  - swap_req is ignored at all other times.
- `FETCH_DBUF_EN` undefined:
  - Single buffer; AW = IMG_W_LOG2+IMG_H_LOG2.
  - swap_req unused; swap_ack tied 0.

## Structure

- Package `vga_pkg`:
  - constants H_ACTIVE = 640, H_TOTAL = 800, V_ACTIVE = 480, V_TOTAL = 525;
  - `typedef logic [7:0] pixel_t`;
  - `typedef logic [9:0] coord_t`.
  - Shared with the VGA controller.
- Sub-module `vga_valid_pipe`: parameterised-depth shift register with synchronous active-low clear. Carries the in-window flag (depth LA).

## Test plan

Defaults unless noted; LA = 2.
- Reset: rst_n = 0 for 3 cycles with x = 200, y = 120.
  - During reset: pixel = 8'h00, mem_rd_en = 0.
  - First cycle after release: mem_rd_en = 1, mem_addr = (8<<8)+10 = 2058.
- Left window edge: x = 190, y = 112.
  - Next cycle: mem_addr = 0.
  - Pixel at x = 190 is BORDER; at x = 192 pixel = ram[0] = 8'hA5.
- Right edge and line wrap:
  - x = 446, y = 150 → mem_rd_en = 0 next cycle.
  - With X0 = 0, Y0 = 0: x = 799, y = 111 → mem_addr = (112<<8)+1 = 28673.
- Scaling, SCALE_LOG2 = 1, X0 = Y0 = 0: x = 5, y = 7 → look-ahead (7, 7) → mem_addr = (3<<8)+3 = 771.
- Double buffer (`FETCH_DBUF_EN`):
  - swap_req = 1 at x = 798, y = 479 → swap_ack = 1 for one cycle, then mem_addr[16] = 1 on the next frame's reads.
  - swap_req = 0 at the same point → no ack, MSB unchanged.
- Reset mid-line at x = 300, y = 200: pixel = BORDER for 2 cycles after release, then correct RAM data with no frame wait.
